// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types and constants for the parking-lot controller: gate FSM states,
// sensor-pair encodings and parameter range checks.
package pklot_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_A_ON     = 3'd1,
        S_B_ON     = 3'd2,
        S_IN_BOTH  = 3'd3,
        S_OUT_BOTH = 3'd4,
        S_IN_B     = 3'd5,
        S_OUT_A    = 3'd6
    } gate_state_e;

    // Sensor pair as {a, b}: a is the outer beam, b the inner beam.
    localparam logic [1:0] AB_CLR  = 2'b00;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_BOTH = 2'b11;

    function automatic bit num_gates_ok(input int n);
        return (n >= 1) && (n <= 8);
    endfunction

    function automatic bit capacity_ok(input int c);
        return (c >= 1) && (c <= 1023);
    endfunction

endpackage

// File: rtl/parking_lot_ctrl_gate_dir_fsm.sv
// One gate's direction decoder: turns the outer/inner beam sequence into
// registered single-cycle enter, exit and seq_err pulses.
module gate_dir_fsm
    import pklot_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ab,
    output logic       enter,
    output logic       exit,
    output logic       seq_err
);

    gate_state_e state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            enter   <= 1'b0;
            exit    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            enter   <= 1'b0;
            exit    <= 1'b0;
            seq_err <= 1'b0;
            case (state_q)
                S_IDLE: case (ab)
                    AB_A:    state_q <= S_A_ON;
                    AB_B:    state_q <= S_B_ON;
                    AB_BOTH: seq_err <= 1'b1;
                    default: ;
                endcase
                S_A_ON: case (ab)
                    AB_CLR:  state_q <= S_IDLE;
                    AB_BOTH: state_q <= S_IN_BOTH;
                    AB_B:    seq_err <= 1'b1;
                    default: ;
                endcase
                S_B_ON: case (ab)
                    AB_CLR:  state_q <= S_IDLE;
                    AB_BOTH: state_q <= S_OUT_BOTH;
                    AB_A:    seq_err <= 1'b1;
                    default: ;
                endcase
                S_IN_BOTH: case (ab)
                    AB_A:    state_q <= S_A_ON;
                    AB_B:    state_q <= S_IN_B;
                    AB_CLR:  seq_err <= 1'b1;
                    default: ;
                endcase
                S_OUT_BOTH: case (ab)
                    AB_B:    state_q <= S_B_ON;
                    AB_A:    state_q <= S_OUT_A;
                    AB_CLR:  seq_err <= 1'b1;
                    default: ;
                endcase
                S_IN_B: case (ab)
                    AB_BOTH: state_q <= S_IN_BOTH;
                    AB_CLR: begin
                        state_q <= S_IDLE;
                        enter   <= 1'b1;
                    end
                    AB_A:    seq_err <= 1'b1;
                    default: ;
                endcase
                S_OUT_A: case (ab)
                    AB_BOTH: state_q <= S_OUT_BOTH;
                    AB_CLR: begin
                        state_q <= S_IDLE;
                        exit    <= 1'b1;
                    end
                    AB_B:    seq_err <= 1'b1;
                    default: ;
                endcase
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-gate parking-lot controller: per-gate direction FSMs feeding one
// saturating occupancy counter. Define PKLOT_SYNC_EN to add 2-flop input synchronizers.
module parking_lot_ctrl
    import pklot_pkg::*;
#(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2*NUM_GATES-1:0]           ab,
    output logic [NUM_GATES-1:0]             enter,
    output logic [NUM_GATES-1:0]             exit,
    output logic [NUM_GATES-1:0]             seq_err,
    output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
    output logic                             full,
    output logic                             empty,
    output logic                             cnt_err
);

    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam int PC_W  = $clog2(NUM_GATES + 1);
    localparam int SUM_W = CNT_W + 1 + PC_W;

    localparam logic [CNT_W-1:0]        CAP_C  = CNT_W'(CAPACITY);
    localparam logic signed [SUM_W-1:0] CAP_S  = SUM_W'(CAPACITY);
    localparam logic signed [SUM_W-1:0] ZERO_S = '0;

    if (!num_gates_ok(NUM_GATES)) begin : g_bad_num_gates
        $error("parking_lot_ctrl: NUM_GATES out of range 1..8");
    end
    if (!capacity_ok(CAPACITY)) begin : g_bad_capacity
        $error("parking_lot_ctrl: CAPACITY out of range 1..1023");
    end

    logic [2*NUM_GATES-1:0] ab_s;

`ifdef PKLOT_SYNC_EN
    logic [2*NUM_GATES-1:0] sync1_q;
    logic [2*NUM_GATES-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ab;
            sync2_q <= sync1_q;
        end
    end
    assign ab_s = sync2_q;
`else
    assign ab_s = ab;
`endif

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        gate_dir_fsm u_fsm (
            .clk     (clk),
            .reset   (reset),
            .ab      (ab_s[2*g +: 2]),
            .enter   (enter[g]),
            .exit    (exit[g]),
            .seq_err (seq_err[g])
        );
    end

    logic [PC_W-1:0]         n_enter;
    logic [PC_W-1:0]         n_exit;
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        occ_d, occ_q;
    logic                    sat_d, cnt_err_q;

    always_comb begin
        n_enter = '0;
        n_exit  = '0;
        for (int unsigned g = 0; g < NUM_GATES; g++) begin
            n_enter = n_enter + PC_W'(enter[g]);
            n_exit  = n_exit  + PC_W'(exit[g]);
        end
    end

    // Only the net change is range-checked, so a coincident enter/exit at full is silent.
    always_comb begin
        sum   = SUM_W'(occ_q) + SUM_W'(n_enter) - SUM_W'(n_exit);
        occ_d = sum[CNT_W-1:0];
        sat_d = 1'b0;
        if (sum < ZERO_S) begin
            occ_d = '0;
            sat_d = 1'b1;
        end else if (sum > CAP_S) begin
            occ_d = CAP_C;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q     <= '0;
            cnt_err_q <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            cnt_err_q <= sat_d;
        end
    end

    assign occupancy = occ_q;
    assign cnt_err   = cnt_err_q;
    assign full      = (occ_q == CAP_C);
    assign empty     = (occ_q == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl: directed passages push expected
// per-cycle output snapshots; a negedge monitor pops and compares them.
module tb_parking_lot_ctrl;

    localparam int NG  = 2;
    localparam int CAP = 16;
`ifdef PKLOT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] ab = '0;
    logic [1:0] enter, exit, seq_err;
    logic [4:0] occupancy;
    logic       full, empty, cnt_err;

    parking_lot_ctrl #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .ab        (ab),
        .enter     (enter),
        .exit      (exit),
        .seq_err   (seq_err),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [13:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [13:0] pack(input logic [1:0] en, input logic [1:0] ex,
                                         input logic [1:0] se, input int occ, input logic ce);
        logic [4:0] o;
        o = 5'(occ);
        return {en, ex, se, o, (occ == CAP), (occ == 0), ce};
    endfunction

    task automatic expect_at(input int unsigned c, input logic [1:0] en, input logic [1:0] ex,
                             input logic [1:0] se, input int occ, input logic ce, input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = pack(en, ex, se, occ, ce);
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Drive one sensor vector; its effect on the pulses appears LAT cycles later.
    task automatic step_chk(input logic [3:0] v, input logic [1:0] en, input logic [1:0] ex,
                            input logic [1:0] se, input int occ, input logic ce, input string nm);
        @(posedge clk);
        #1;
        ab = v;
        expect_at(cyc + LAT, en, ex, se, occ, ce, nm);
    endtask

    task automatic pass(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                        input logic [1:0] en, input logic [1:0] ex,
                        input int ob, input int oa, input logic ce, input string nm);
        step_chk(v0, 2'b00, 2'b00, 2'b00, ob, 1'b0, {nm, "_s0"});
        step_chk(v1, 2'b00, 2'b00, 2'b00, ob, 1'b0, {nm, "_s1"});
        step_chk(v2, 2'b00, 2'b00, 2'b00, ob, 1'b0, {nm, "_s2"});
        step_chk(4'b0000, en, ex, 2'b00, ob, 1'b0, {nm, "_pulse"});
        step_chk(4'b0000, 2'b00, 2'b00, 2'b00, oa, ce, {nm, "_occ"});
        step_chk(4'b0000, 2'b00, 2'b00, 2'b00, oa, 1'b0, {nm, "_hold"});
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [13:0] got;
        got = {enter, exit, seq_err, occupancy, full, empty, cnt_err};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: slot for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
            end else if (got !== e.v) begin
                errors++;
                $display("FAIL %s @%0d: got en=%b ex=%b se=%b occ=%0d full=%b empty=%b cerr=%b, expected en=%b ex=%b se=%b occ=%0d full=%b empty=%b cerr=%b",
                         e.nm, cyc, got[13:12], got[11:10], got[9:8], got[7:3], got[2], got[1], got[0],
                         e.v[13:12], e.v[11:10], e.v[9:8], e.v[7:3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        ab    = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_at(cyc, 2'b00, 2'b00, 2'b00, 0, 1'b0, "reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;

        step_chk(4'b0000, 2'b00, 2'b00, 2'b00, 0, 1'b0, "idle_after_reset");
        pass(4'b0010, 4'b0011, 4'b0001, 2'b01, 2'b00, 0, 1, 1'b0, "enter_g0");
        pass(4'b1010, 4'b1111, 4'b0101, 2'b11, 2'b00, 1, 3, 1'b0, "enter_both");
        pass(4'b0100, 4'b1100, 4'b1000, 2'b00, 2'b10, 3, 2, 1'b0, "exit_g1");
        pass(4'b0010, 4'b0011, 4'b0010, 2'b00, 2'b00, 2, 2, 1'b0, "backout_g0");
        pass(4'b0001, 4'b0011, 4'b0010, 2'b00, 2'b01, 2, 1, 1'b0, "exit_g0_after_backout");

        // Illegal jumps: IDLE sees 11 twice, then A_ON sees 01; the enter that
        // follows proves A_ON was held through the error.
        step_chk(4'b0011, 2'b00, 2'b00, 2'b01, 1, 1'b0, "seq_idle_11");
        step_chk(4'b0011, 2'b00, 2'b00, 2'b01, 1, 1'b0, "seq_idle_11_again");
        step_chk(4'b0000, 2'b00, 2'b00, 2'b00, 1, 1'b0, "seq_idle_00");
        step_chk(4'b0010, 2'b00, 2'b00, 2'b00, 1, 1'b0, "seq_a_on");
        step_chk(4'b0001, 2'b00, 2'b00, 2'b01, 1, 1'b0, "seq_a_on_01");
        pass(4'b0011, 4'b0011, 4'b0001, 2'b01, 2'b00, 1, 2, 1'b0, "enter_after_seqerr");

        pass(4'b1000, 4'b1100, 4'b0100, 2'b10, 2'b00, 2, 3, 1'b0, "enter_g1");
        for (int i = 0; i < 6; i++)
            pass(4'b1010, 4'b1111, 4'b0101, 2'b11, 2'b00, 3 + 2*i, 5 + 2*i, 1'b0, "fill_both");
        pass(4'b1010, 4'b1111, 4'b0101, 2'b11, 2'b00, 15, 16, 1'b1, "sat_high");
        pass(4'b0110, 4'b1111, 4'b1001, 2'b01, 2'b10, 16, 16, 1'b0, "mixed_at_full");
        for (int i = 0; i < 5; i++)
            pass(4'b0101, 4'b1111, 4'b1010, 2'b00, 2'b11, 16 - 2*i, 14 - 2*i, 1'b0, "drain_both");
        pass(4'b0001, 4'b0011, 4'b0010, 2'b00, 2'b01, 6, 5, 1'b0, "exit_to_5");

        step_chk(4'b0010, 2'b00, 2'b00, 2'b00, 5, 1'b0, "rst_a_on");
        step_chk(4'b0011, 2'b00, 2'b00, 2'b00, 5, 1'b0, "rst_in_both");
        step_chk(4'b0001, 2'b00, 2'b00, 2'b00, 5, 1'b0, "rst_in_b");
        repeat (LAT + 1) @(posedge clk);
        #2;
        reset = 1'b0;
        expect_at(cyc, 2'b00, 2'b00, 2'b00, 0, 1'b0, "reset_mid_passage");
        @(posedge clk);
        #1;
        reset = 1'b1;
        ab    = 4'b0000;
        repeat (LAT + 2) step_chk(4'b0000, 2'b00, 2'b00, 2'b00, 0, 1'b0, "no_enter_after_reset");

        pass(4'b0001, 4'b0011, 4'b0010, 2'b00, 2'b01, 0, 0, 1'b1, "underflow");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expected slot at cycle %0d never checked (now %0d)", e.nm, e.cyc, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
